// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: drives a request/ack instruction memory and feeds
// the IF/ID register. It holds one fetched word while the pipeline is stalled,
// and it drains a request that a redirect has made obsolete.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] PC_o,
    output logic [31:0] instr_o,
    output logic        IF_ID_Write_o,
    output logic        IF_Flush_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DROP
    } state_t;

    localparam logic [31:0] RESET_PC_WORD = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] drop_addr_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_instr_q;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_word;

    assign pc_plus4      = pc_q + 32'd4;
    assign redirect_word = redirect_pc_i & 32'hFFFF_FFFC;

    // Memory-side and pipeline-side outputs decoded from the state and the current inputs
    always_comb begin
        imem_req_o    = 1'b0;
        imem_addr_o   = pc_q;
        IF_ID_Write_o = 1'b0;
        IF_Flush_o    = 1'b0;
        PC_o          = '0;
        instr_o       = '0;
        case (state_q)
            IDLE: begin
            end
            FETCH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_q;
                PC_o        = pc_plus4;
                instr_o     = imem_ack_i ? imem_data_i : '0;
                if (redirect_i) begin
                    IF_Flush_o = 1'b1;
                end else if (imem_ack_i) begin
                    IF_ID_Write_o = !stall_i;
                end else begin
                    IF_Flush_o = !stall_i;
                end
            end
            HOLD: begin
                PC_o    = buf_pc_q;
                instr_o = buf_instr_q;
                if (redirect_i) begin
                    IF_Flush_o = 1'b1;
                end else begin
                    IF_ID_Write_o = !stall_i;
                end
            end
            DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drop_addr_q;
                IF_Flush_o  = !stall_i;
            end
            default: begin
            end
        endcase
    end

    // Fetch sequencing: PC update, stall buffering and obsolete-request draining
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC_WORD;
            drop_addr_q <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (redirect_i) begin
                        pc_q <= redirect_word;
                        if (!imem_ack_i) begin
                            // The request must still complete at its original address.
                            drop_addr_q <= pc_q;
                            state_q     <= DROP;
                        end
                    end else if (imem_ack_i) begin
                        pc_q <= pc_plus4;
                        if (stall_i) begin
                            buf_pc_q    <= pc_plus4;
                            buf_instr_q <= imem_data_i;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_word;
                        state_q <= FETCH;
                    end else if (!stall_i) begin
                        state_q <= FETCH;
                    end
                end
                DROP: begin
                    if (redirect_i) begin
                        pc_q <= redirect_word;
                    end
                    if (imem_ack_i) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios with literal expectations, then
// randomized stall/redirect/latency/reset traffic checked against a
// transaction-level model of the fetch stream.
module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        wr_en;
    logic        flush;

    int n_checks = 0;
    int n_errors = 0;
    int lat_fixed = 0;   // < 0 selects a random ack latency per request

    if_stage_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_data_i  (imem_data),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .PC_o         (pc_out),
        .instr_o      (instr_out),
        .IF_ID_Write_o(wr_en),
        .IF_Flush_o   (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: a request is acked after a chosen number of wait cycles
    int  mem_cnt = 0;
    bit  mem_pending = 0;
    always @(posedge clk) begin
        logic r;
        r = rst;
        #1;
        if (r) mem_pending = 0;
        if (imem_req) begin
            if (!mem_pending) begin
                mem_pending = 1;
                mem_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end
            if (mem_cnt == 0) begin
                imem_ack  = 1'b1;
                imem_data = word_of(imem_addr);
                mem_pending = 0;
            end else begin
                imem_ack  = 1'b0;
                imem_data = $urandom;
                mem_cnt--;
            end
        end else begin
            imem_ack  = 1'b0;
            imem_data = $urandom;
        end
    end

    // Transaction-level model: the stage is either idle after reset, presenting a
    // buffered word, waiting out a request whose data is unwanted, or fetching at m_pc.
    bit          m_valid = 0;
    bit          m_idle, m_buf, m_kill;
    logic [31:0] m_pc, m_kill_addr, m_buf_pc, m_buf_ins;
    bit          p_req = 0, p_ack = 0, p_rst = 1;
    logic [31:0] p_addr = '0;

    always @(negedge clk) begin
        logic        e_req, e_wr, e_fl;
        logic [31:0] e_addr, e_pc, e_ins, tgt;
        if (m_valid) begin
            e_req = 1'b0; e_wr = 1'b0; e_fl = 1'b0; e_addr = '0; e_pc = '0; e_ins = '0;
            if (m_idle) begin
                e_pc = '0; e_ins = '0;
            end else if (m_buf) begin
                e_pc = m_buf_pc; e_ins = m_buf_ins;
                e_fl = redirect;
                e_wr = !redirect && !stall;
            end else if (m_kill) begin
                e_req = 1'b1; e_addr = m_kill_addr;
                e_fl = !stall;
            end else begin
                e_req = 1'b1; e_addr = m_pc;
                e_pc = m_pc + 32'd4; e_ins = word_of(m_pc);
                e_fl = redirect || (!imem_ack && !stall);
                e_wr = !redirect && imem_ack && !stall;
            end
            chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
            chk("if_id_write", {31'b0, wr_en}, {31'b0, e_wr});
            chk("if_flush", {31'b0, flush}, {31'b0, e_fl});
            if (e_req) chk("imem_addr", imem_addr, e_addr);
            if (e_wr || m_idle) begin
                chk("pc_o", pc_out, e_pc);
                chk("instr_o", instr_out, e_ins);
            end
            if (p_req && !p_ack && !p_rst) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_held", imem_addr, p_addr);
            end
        end
        if (wr_en && flush) chk("write_flush_exclusive", 32'd1, 32'd0);
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_rst = rst;
        // advance the model to the state after the coming rising edge
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (rst) begin
            m_valid = 1; m_idle = 1; m_buf = 0; m_kill = 0; m_pc = 32'h0;
        end else if (m_valid) begin
            if (m_idle) begin
                m_idle = 0;
            end else if (m_buf) begin
                if (redirect) begin m_buf = 0; m_pc = tgt; end
                else if (!stall) m_buf = 0;
            end else if (m_kill) begin
                if (redirect) m_pc = tgt;
                if (imem_ack) m_kill = 0;
            end else if (redirect) begin
                if (!imem_ack) begin m_kill = 1; m_kill_addr = m_pc; end
                m_pc = tgt;
            end else if (imem_ack) begin
                if (stall) begin m_buf = 1; m_buf_pc = m_pc + 32'd4; m_buf_ins = word_of(m_pc); end
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst = r; stall = st; redirect = rd; redirect_pc = rpc;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_data = '0;
        lat_fixed = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // idle cycle after reset
        cyc(0, 0, 0, 0);
        chk("lit_idle_req", {31'b0, imem_req}, 32'd0);
        chk("lit_idle_pc", pc_out, 32'd0);
        chk("lit_idle_instr", instr_out, 32'd0);
        // single-cycle memory streaming
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("lit_stream_wr", {31'b0, wr_en}, 32'd1);
            chk("lit_stream_pc", pc_out, 32'd4 * (i + 1));
            chk("lit_stream_instr", instr_out, word_of(32'd4 * i));
        end
        // slow memory at 0x10: two bubbles then the word
        cyc(0, 0, 1, 32'h10);
        chk("lit_redir_flush", {31'b0, flush}, 32'd1);
        lat_fixed = 2;
        for (int unsigned i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0);
            chk("lit_slow_flush", {31'b0, flush}, 32'd1);
            chk("lit_slow_addr", imem_addr, 32'h10);
        end
        lat_fixed = 0;
        cyc(0, 0, 0, 0);
        chk("lit_slow_addr3", imem_addr, 32'h10);
        chk("lit_slow_wr", {31'b0, wr_en}, 32'd1);
        chk("lit_slow_pc", pc_out, 32'h14);
        // stall while acked at 0x20
        cyc(0, 0, 1, 32'h20);
        cyc(0, 1, 0, 0);
        chk("lit_stall_addr", imem_addr, 32'h20);
        chk("lit_stall_wr", {31'b0, wr_en}, 32'd0);
        cyc(0, 1, 0, 0);
        chk("lit_hold_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 1, 0, 0);
        chk("lit_hold_wr", {31'b0, wr_en}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("lit_release_wr", {31'b0, wr_en}, 32'd1);
        chk("lit_release_pc", pc_out, 32'h24);
        chk("lit_release_instr", instr_out, word_of(32'h20));
        cyc(0, 0, 0, 0);
        chk("lit_after_hold_addr", imem_addr, 32'h24);
        // redirect while 0x40 outstanding
        cyc(0, 0, 1, 32'h40);
        lat_fixed = 3;
        cyc(0, 0, 1, 32'h103);
        chk("lit_drop_flush", {31'b0, flush}, 32'd1);
        chk("lit_drop_addr0", imem_addr, 32'h40);
        lat_fixed = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("lit_drop_addr", imem_addr, 32'h40);
            chk("lit_drop_wr", {31'b0, wr_en}, 32'd0);
        end
        cyc(0, 0, 0, 0);
        chk("lit_after_drop_addr", imem_addr, 32'h100);
        chk("lit_after_drop_pc", pc_out, 32'h104);
        // wrap-around
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_pc", pc_out, 32'h0);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_addr", imem_addr, 32'h0);
        // reset in the middle of draining
        lat_fixed = 3;
        cyc(0, 0, 1, 32'h80);
        cyc(1, 0, 0, 0);
        lat_fixed = 0;
        cyc(0, 0, 0, 0);
        chk("lit_rst_req", {31'b0, imem_req}, 32'd0);
        chk("lit_rst_flush", {31'b0, flush}, 32'd0);
        chk("lit_rst_pc", pc_out, 32'd0);
        cyc(0, 0, 0, 0);
        chk("lit_rst_fetch_addr", imem_addr, 32'h0);
        chk("lit_rst_fetch_pc", pc_out, 32'h4);
        // randomized traffic
        lat_fixed = -1;
        for (int unsigned i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) == 0),
                $urandom);
        end
        cyc(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
